// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing a single-ported memory between the CPU and a loader/DMA port.
// Optional ARB_CPU_PRIORITY_EN: fixed CPU priority instead of round-robin arbitration.
module mem_port_arbiter #(
    parameter int unsigned AW  = 8,
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int unsigned CW      = 4;
    localparam logic        OWN_CPU = 1'b0;
    localparam logic        OWN_LDR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            owner;
    logic [CW-1:0]   wait_cnt;
    logic            grant_c;
    logic            grant_ldr_c;
`ifndef ARB_CPU_PRIORITY_EN
    logic            last_grant;
`endif

    // Grant decision for the current IDLE cycle
    always_comb begin
        grant_c = cpu_req | ldr_req;
`ifdef ARB_CPU_PRIORITY_EN
        grant_ldr_c = ldr_req & ~cpu_req;
`else
        grant_ldr_c = ldr_req & (~cpu_req | (last_grant == OWN_CPU));
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (grant_c) state_n = S_ISSUE;
            S_ISSUE:   state_n = (LAT == 1) ? S_CAPTURE : S_WAIT;
            S_WAIT:    if (wait_cnt == CW'(1)) state_n = S_CAPTURE;
            S_CAPTURE: state_n = S_RESP;
            S_RESP:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_CPU;
`ifndef ARB_CPU_PRIORITY_EN
            last_grant <= OWN_LDR;
`endif
            wait_cnt   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            mem_en  <= (state_n == S_ISSUE);
            busy    <= (state_n != S_IDLE);
            cpu_ack <= (state_n == S_RESP) && (owner == OWN_CPU);
            ldr_ack <= (state_n == S_RESP) && (owner == OWN_LDR);

            if ((state == S_IDLE) && grant_c) begin
                owner      <= grant_ldr_c;
`ifndef ARB_CPU_PRIORITY_EN
                last_grant <= grant_ldr_c;
`endif
                mem_we     <= grant_ldr_c ? ldr_we    : cpu_we;
                mem_addr   <= grant_ldr_c ? ldr_addr  : cpu_addr;
                mem_wdata  <= grant_ldr_c ? ldr_wdata : cpu_wdata;
            end

            if (state == S_ISSUE) begin
                wait_cnt <= CW'(LAT - 1);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - CW'(1);
            end

            if (state == S_CAPTURE) begin
                if (owner == OWN_LDR) begin
                    ldr_rdata <= mem_rdata;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
